// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants for the UART receive path
//
// Purpose: sizing constants used by the UART receive buffer and its helpers.
//   UART_BYTE_W     : width of one received character
//   UART_FIFO_DEPTH : default receive FIFO depth (power of two)
//   UART_FIFO_AW    : log2 of UART_FIFO_DEPTH, pointer width
package uart_pkg;

  localparam int UART_BYTE_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;
  localparam int UART_FIFO_AW    = 4;

endpackage : uart_pkg

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer with configurable reset value
//
// Purpose: brings an asynchronous UART level into the clk domain.
// Ports:
//   clk   : destination clock
//   rst   : asynchronous active-low reset, loads RESET_VAL into both flops
//   level : asynchronous input level
//   sync  : synchronized level, two clk edges behind level
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic sync
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
    end else begin
      meta <= level;
      sync <= meta;
    end
  end

endmodule : uart_sync

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO behind the UART receiver
//
// Purpose: captures each completed byte on the rising edge of the receiver's
// ready level, buffers it in a DEPTH-entry circular FIFO and hands it to the
// consumer through a registered one-cycle-latency read.
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   rx_byte    : received byte, stable while rx_ready is high
//   rx_ready   : receiver ready level, asynchronous to clk
//   rd_en      : consumer read request, one byte per asserted cycle
//   dout       : registered read data
//   dout_valid : one-cycle pulse, dout holds a newly read byte
//   empty      : no bytes stored
//   full       : DEPTH bytes stored
//   count      : number of bytes stored, 0..DEPTH
//   overflow   : sticky, at least one byte was dropped
//   ovf_clr    : clears overflow
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int ADDR_W = UART_FIFO_AW
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_BYTE_W-1:0] rx_byte,
  input  logic                   rx_ready,
  input  logic                   rd_en,
  output logic [UART_BYTE_W-1:0] dout,
  output logic                   dout_valid,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        count,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [UART_BYTE_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr;
  logic [ADDR_W-1:0]      rd_ptr;
  logic                   ready_sync;
  logic                   ready_prev;
  logic                   wr_stb;
  logic                   rd_acc;
  logic                   wr_acc;
  logic                   drop;
  logic [ADDR_W:0]        count_nxt;

  // Both flops reset high so a reset released while the line idles high
  // never looks like a completed byte.
  uart_sync #(.RESET_VAL(1'b1)) u_ready_sync (
    .clk   (clk),
    .rst   (rst),
    .level (rx_ready),
    .sync  (ready_sync)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_prev <= 1'b1;
    else      ready_prev <= ready_sync;
  end

  assign wr_stb = ready_sync & ~ready_prev;

  // A read in the same cycle frees a slot, so a full FIFO still accepts.
  // An empty FIFO never bypasses: the read is ignored, the write lands.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_stb & (~full | rd_acc);
  assign drop   = wr_stb & full & ~rd_acc;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= rx_byte;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      overflow   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        dout   <= mem[rd_ptr];
      end
      dout_valid <= rd_acc;
      count      <= count_nxt;
      empty      <= (count_nxt == '0);
      full       <= (count_nxt == COUNT_FULL);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_ready;
  logic       rd_en;
  logic [7:0] dout;
  logic       dout_valid;
  logic       empty;
  logic       full;
  logic [4:0] count;
  logic       overflow;
  logic       ovf_clr;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_q[$];
  logic       exp_ovf;
  logic       got_v[$];
  logic [7:0] got_d[$];

  always #5 clk = ~clk;

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_byte    (rx_byte),
    .rx_ready   (rx_ready),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One receiver byte: ready low for a while, then rise with the data.
  // Returns 3 edges after the rise, when the write is visible.
  task automatic send_byte(input logic [7:0] b);
    rx_ready = 1'b0;
    repeat (3) tick();
    rx_byte  = b;
    rx_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic model_write(input logic [7:0] b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else                        exp_ovf = 1'b1;
  endtask

  task automatic read_n(input int n);
    got_v.delete();
    got_d.delete();
    rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      got_v.push_back(dout_valid);
      got_d.push_back(dout);
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_ready = 1'b1; rx_byte = 8'h5A; rd_en = 1'b0; ovf_clr = 1'b0;
    exp_ovf = 1'b0;
    model_q.delete();
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (dout_valid !== 1'b0) begin bad++; $display("FAIL reset_dv cyc%0d got=%b exp=0", i, dout_valid); end
    end
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL reset_state got cnt=%0d emp=%b full=%b ovf=%b dout=%h exp 0/1/0/0/00",
               count, empty, full, overflow, dout);
    end
  endtask

  task automatic test_basic();
    logic [7:0] seq [3];
    seq[0] = 8'hA5; seq[1] = 8'h3C; seq[2] = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      send_byte(seq[i]);
      model_write(seq[i]);
    end
    total++;
    if (count !== 5'd3 || empty !== 1'b0) begin bad++; $display("FAIL basic_count got=%0d emp=%b exp=3/0", count, empty); end
    read_n(3);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_v[i] !== 1'b1 || got_d[i] !== seq[i]) begin
        bad++; $display("FAIL basic_rd%0d got v=%b d=%h exp v=1 d=%h", i, got_v[i], got_d[i], seq[i]);
      end
      void'(model_q.pop_front());
    end
    tick();
    total++;
    if (empty !== 1'b1 || dout_valid !== 1'b0 || dout !== 8'hFF) begin
      bad++; $display("FAIL basic_after got emp=%b dv=%b dout=%h exp 1/0/ff", empty, dout_valid, dout);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 17; i++) begin
      send_byte(8'(i));
      model_write(8'(i));
      if (i == 15) begin
        total++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
          bad++; $display("FAIL ovf_full got full=%b cnt=%0d ovf=%b exp 1/16/0", full, count, overflow);
        end
      end
    end
    total++;
    if (overflow !== exp_ovf || overflow !== 1'b1 || count !== 5'd16) begin
      bad++; $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1/16", overflow, count);
    end
    read_n(16);
    for (int i = 0; i < 16; i++) begin
      total++;
      if (got_v[i] !== 1'b1 || got_d[i] !== 8'(i)) begin
        bad++; $display("FAIL ovf_rd%0d got v=%b d=%h exp v=1 d=%h", i, got_v[i], got_d[i], 8'(i));
      end
      void'(model_q.pop_front());
    end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0; exp_ovf = 1'b0;
    total++;
    if (overflow !== 1'b0 || empty !== 1'b1) begin
      bad++; $display("FAIL ovf_clr got ovf=%b emp=%b exp 0/1", overflow, empty);
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] b;
    logic [7:0] exp_old;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_byte(b);
      model_write(b);
    end
    b = 8'($urandom);
    rx_ready = 1'b0;
    repeat (3) tick();
    rx_byte = b; rx_ready = 1'b1;
    tick(); tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    exp_old = model_q.pop_front();
    model_q.push_back(b);
    total++;
    if (dout_valid !== 1'b1 || dout !== exp_old) begin
      bad++; $display("FAIL simul_rd got v=%b d=%h exp v=1 d=%h", dout_valid, dout, exp_old);
    end
    total++;
    if (count !== 5'd16 || full !== 1'b1 || overflow !== 1'b0) begin
      bad++; $display("FAIL simul_state got cnt=%0d full=%b ovf=%b exp 16/1/0", count, full, overflow);
    end
    read_n(DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      exp_old = model_q.pop_front();
      total++;
      if (got_v[i] !== 1'b1 || got_d[i] !== exp_old) begin
        bad++; $display("FAIL simul_drain%0d got v=%b d=%h exp v=1 d=%h", i, got_v[i], got_d[i], exp_old);
      end
    end
  endtask

  task automatic test_interleave();
    logic [7:0] b;
    logic [7:0] e;
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom);
      send_byte(b);
      model_write(b);
      read_n(1);
      e = model_q.pop_front();
      total++;
      if (got_v[0] !== 1'b1 || got_d[0] !== e) begin
        bad++; $display("FAIL inter%0d got v=%b d=%h exp v=1 d=%h", i, got_v[0], got_d[0], e);
      end
    end
    tick();
    total++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      bad++; $display("FAIL inter_end got emp=%b cnt=%0d exp 1/0", empty, count);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [7:0] e;
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_byte(b);
      model_write(b);
    end
    // A drop coinciding with a clear leaves the flag set.
    ovf_clr = 1'b1;
    send_byte(8'hEE);
    model_write(8'hEE);
    ovf_clr = 1'b0;
    total++;
    if (overflow !== 1'b1) begin bad++; $display("FAIL drop_vs_clr got ovf=%b exp 1", overflow); end
    read_n(11);
    repeat (11) void'(model_q.pop_front());
    total++;
    if (count !== 5'd5 || dout_valid !== 1'b1) begin
      bad++; $display("FAIL mid_pre got cnt=%0d dv=%b exp 5/1", count, dout_valid);
    end
    // Reset between edges, with a byte completing while reset is held.
    rx_ready = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_q.delete(); exp_ovf = 1'b0;
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || overflow !== 1'b0 || dout_valid !== 1'b0 || dout !== 8'h00) begin
      bad++;
      $display("FAIL mid_reset got cnt=%0d emp=%b ovf=%b dv=%b dout=%h exp 0/1/0/0/00",
               count, empty, overflow, dout_valid, dout);
    end
    tick();
    rx_byte = 8'h77; rx_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (5) tick();
    total++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      bad++; $display("FAIL mid_lost got cnt=%0d emp=%b exp 0/1", count, empty);
    end
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_byte(b);
      model_write(b);
    end
    read_n(4);
    for (int i = 0; i < 4; i++) begin
      e = model_q.pop_front();
      total++;
      if (got_v[i] !== 1'b1 || got_d[i] !== e) begin
        bad++; $display("FAIL mid_after%0d got v=%b d=%h exp v=1 d=%h", i, got_v[i], got_d[i], e);
      end
    end
  endtask

  task automatic test_random_mix();
    int op;
    int n;
    logic [7:0] b;
    logic [7:0] e;
    for (int k = 0; k < 70; k++) begin
      op = int'($urandom_range(0, 5));
      if (op <= 2) begin
        b = 8'($urandom);
        send_byte(b);
        model_write(b);
      end else if (op <= 4) begin
        n = int'($urandom_range(1, 3));
        read_n(n);
        for (int i = 0; i < n; i++) begin
          total++;
          if (model_q.size() > 0) begin
            e = model_q.pop_front();
            if (got_v[i] !== 1'b1 || got_d[i] !== e) begin
              bad++; $display("FAIL mix%0d_rd%0d got v=%b d=%h exp v=1 d=%h", k, i, got_v[i], got_d[i], e);
            end
          end else if (got_v[i] !== 1'b0) begin
            bad++; $display("FAIL mix%0d_rd%0d got v=%b exp v=0 (empty)", k, i, got_v[i]);
          end
        end
      end else begin
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        exp_ovf = 1'b0;
      end
      total++;
      if (count !== 5'(model_q.size()) || overflow !== exp_ovf ||
          empty !== (model_q.size() == 0) || full !== (model_q.size() == DEPTH)) begin
        bad++;
        $display("FAIL mix%0d_state got cnt=%0d ovf=%b emp=%b full=%b exp cnt=%0d ovf=%b",
                 k, count, overflow, empty, full, model_q.size(), exp_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_interleave();
    test_reset_mid();
    test_random_mix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_rx_fifo

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. Detects each completed byte from the receiver's ready level, stores the byte in a DEPTH-entry circular FIFO, and presents it to the consuming logic through a registered read handshake. Decouples the baud-rate byte arrival from the system-clock consumer and reports loss through a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset; asserting low resets all state immediately, deassertion is synchronous to clk.
- rx_byte  in  8  received byte from the receiver; stable from ready rise until the next start bit.
- rx_ready  in  1  receiver ready level; idle high, low while a byte is in flight, rises when the byte completes; asynchronous to clk.
- rd_en  in  1  consumer read request, one byte per cycle asserted.
- dout  out  8  registered read data.
- dout_valid  out  1  one-cycle pulse: dout holds a newly read byte.
- empty  out  1  FIFO holds no bytes.
- full  out  1  FIFO holds DEPTH bytes.
- count  out  ADDR_W+1  bytes stored, 0..DEPTH.
- overflow  out  1  sticky: at least one byte dropped.
- ovf_clr  in  1  clears overflow.

## Operation
- rx_ready passes through a 2-flop synchronizer, then a rising-edge detector (third flop); a detected rise is the write strobe wr_stb, one cycle wide.
- Synchronizer and edge flops reset to 1, so a reset while rx_ready is high never produces a write.
- Write: wr_stb and (not full, or rd accepted same cycle) -> mem[wr_ptr] <= rx_byte, wr_ptr increments.
- Read accepted: rd_en and not empty -> dout <= mem[rd_ptr], rd_ptr increments, dout_valid = 1 next cycle. rd_en while empty is ignored: no pointer move, no dout_valid, dout holds.
- Pointers are ADDR_W bits, wrap DEPTH-1 -> 0 modulo DEPTH.
- count: +1 on write only, -1 on read only, unchanged on both or neither. empty = (count == 0), full = (count == DEPTH), both registered-consistent with count.
- Simultaneous write and read while full: both proceed, count stays DEPTH, no overflow.
- Simultaneous write and read while empty: write proceeds, read ignored (data not bypassed); count becomes 1.
- Overflow: wr_stb while full with no accepted read -> byte dropped, pointers and memory unchanged, overflow <= 1. ovf_clr clears; a drop in the same cycle as ovf_clr wins (overflow stays 1).
- Reset values: wr_ptr 0, rd_ptr 0, count 0, empty 1, full 0, overflow 0, dout 8'h00, dout_valid 0. Memory contents are not reset.
- Reset mid-operation: all stored bytes discarded; a byte whose ready rise occurs during reset is lost.

## Timing
- rx_ready rise to mem write: 3 clk rising edges (2 sync + edge detect); empty deasserts and count updates on the write edge.
- rd_en accepted at edge N -> dout/dout_valid valid after edge N, i.e. one-cycle read latency; back-to-back reads sustain one byte per cycle.
- rx_ready pulses narrower than 2 clk periods are not guaranteed detected; receiver high/low phases are byte-times long, so no restriction in practice.
- overflow sets on the edge of the dropped write.

## Structure
- Shared package uart_pkg: UART_FIFO_DEPTH (16), UART_FIFO_AW (4), byte width constant (8).
- One sub-module: uart_sync, a parameterised-reset-value 2-flop synchronizer, reused for any other asynchronous UART level.
- Pointer/count logic and memory stay in uart_rx_fifo.

## Test plan
- Reset with rx_ready high, release -> no write; empty=1, count=0, dout=8'h00, dout_valid never pulses.
- Drive 3 ready cycles with bytes 8'hA5, 8'h3C, 8'hFF -> count=3; 3 consecutive rd_en -> dout_valid on 3 consecutive cycles with A5, 3C, FF; empty=1 after.
- Write 17 bytes 8'h00..8'h10 with no reads -> full=1 after 16th, 17th dropped, overflow=1; read 16 -> 00..0F; pulse ovf_clr -> overflow=0.
- Full FIFO, write strobe coincident with rd_en -> oldest byte read, new byte stored, count stays 16, overflow stays 0.
- Write/read 40 bytes interleaved (1 in, 1 out) -> pointers wrap twice, output order matches input exactly.
- Assert rst low mid-stream with count=5 -> immediately count=0, empty=1, overflow=0, dout_valid=0; following bytes stored from pointer 0.
